// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter for one shared two_to_one_mux. It drives the mux select and
// enforces a hold limit so that neither requester can starve the other.
module mux_share_arbiter #(
   parameter  int MAX_HOLD = 8,
   localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic             busy,
   output logic [CNT_W-1:0] hold_cnt
);

   // state | meaning
   // IDLE  | no owner; sel keeps the last routing
   // OWN0  | requester 0 owns the mux, sel=0
   // OWN1  | requester 1 owns the mux, sel=1
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_nxt;
   logic             sel_q, sel_nxt;
   logic             last_q, last_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel_q  <= 1'b0;
         last_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         state  <= state_nxt;
         sel_q  <= sel_nxt;
         last_q <= last_nxt;
         cnt_q  <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      last_nxt  = last_q;
      cnt_nxt   = cnt_q;
      unique case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_nxt = last_q ? OWN0 : OWN1;
               sel_nxt   = ~last_q;
               last_nxt  = ~last_q;
               cnt_nxt   = '0;
            end else if (req0) begin
               state_nxt = OWN0;
               sel_nxt   = 1'b0;
               last_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else if (req1) begin
               state_nxt = OWN1;
               sel_nxt   = 1'b1;
               last_nxt  = 1'b1;
               cnt_nxt   = '0;
            end
         end
         OWN0: begin
            // A dropped request always wins over the hold limit on the same edge.
            if (!req0 && req1) begin
               state_nxt = OWN1;
               sel_nxt   = 1'b1;
               last_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else if (!req0) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (req1 && cnt_q == HOLD_LAST) begin
               state_nxt = OWN1;
               sel_nxt   = 1'b1;
               last_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else if (cnt_q != HOLD_LAST) begin
               cnt_nxt = cnt_q + 1'b1;
            end
         end
         OWN1: begin
            if (!req1 && req0) begin
               state_nxt = OWN0;
               sel_nxt   = 1'b0;
               last_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else if (!req1) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (req0 && cnt_q == HOLD_LAST) begin
               state_nxt = OWN0;
               sel_nxt   = 1'b0;
               last_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else if (cnt_q != HOLD_LAST) begin
               cnt_nxt = cnt_q + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign gnt0     = (state == OWN0);
   assign gnt1     = (state == OWN1);
   assign busy     = (state == OWN0) || (state == OWN1);
   assign sel      = sel_q;
   assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: a cycle model pushes the expected outputs for each edge
// into a queue, and each scenario task pops and compares them after that edge.
module tb_mux_share_arbiter;
   localparam int MAX_HOLD = 8;
   localparam int CNT_W    = $clog2(MAX_HOLD + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 1'b0;
   logic req1 = 1'b0;
   logic gnt0, gnt1, sel, busy;
   logic [CNT_W-1:0] hold_cnt;

   mux_share_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy), .hold_cnt(hold_cnt)
   );

   always #5 clk = ~clk;

   // Packed as {gnt0, gnt1, sel, busy, hold_cnt}.
   logic [CNT_W+3:0] obs, exp_v;
   assign obs = {gnt0, gnt1, sel, busy, hold_cnt};

   logic [CNT_W+3:0] sb[$];
   int tests_run = 0;
   int tests_failed = 0;

   // Model state: owner -1 means nobody holds the mux.
   int m_owner = -1;
   int m_cnt = 0;
   bit m_sel = 1'b0;
   bit m_last = 1'b1;

   function automatic void m_grant(int x);
      m_owner = x;
      m_cnt   = 0;
      m_last  = bit'(x);
      m_sel   = bit'(x);
   endfunction

   // Sets the inputs for the next edge, advances the model and queues the outcome.
   task automatic drive(bit r, bit a, bit b);
      bit mine, other;
      rst_n = r; req0 = a; req1 = b;
      if (!r) begin
         m_owner = -1; m_cnt = 0; m_sel = 1'b0; m_last = 1'b1;
      end else if (m_owner < 0) begin
         if (a && b)  m_grant(m_last ? 0 : 1);
         else if (a)  m_grant(0);
         else if (b)  m_grant(1);
      end else begin
         mine  = (m_owner == 0) ? a : b;
         other = (m_owner == 0) ? b : a;
         if (!mine && other)                          m_grant(1 - m_owner);
         else if (!mine)                              begin m_owner = -1; m_cnt = 0; end
         else if (other && m_cnt == MAX_HOLD - 1)     m_grant(1 - m_owner);
         else if (m_cnt < MAX_HOLD - 1)               m_cnt++;
      end
      sb.push_back({m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, CNT_W'(m_cnt)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1);
         exp_v = sb.pop_front(); tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_model cyc%0d got %h want %h", i, obs, exp_v);
         end
      end
      tests_run++;
      if ({gnt0, gnt1, sel, busy, hold_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL reset_zero got %h want 0", obs);
      end
      drive(1'b1, 1'b1, 1'b1);
      exp_v = sb.pop_front(); tests_run++;
      if (obs !== exp_v || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_first_grant got %h want %h (gnt0=1)", obs, exp_v);
      end
   endtask

   task automatic test_single();
      bit pat[3][2] = '{'{0, 0}, '{0, 1}, '{0, 0}};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pat[i][0], pat[i][1]);
         exp_v = sb.pop_front(); tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL single step%0d got %h want %h", i, obs, exp_v);
         end
      end
      tests_run++;
      if (sel !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_sel_hold got sel=%b busy=%b want sel=1 busy=0", sel, busy);
      end
   endtask

   task automatic test_direct();
      bit pat[3][2] = '{'{1, 0}, '{1, 1}, '{0, 1}};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pat[i][0], pat[i][1]);
         exp_v = sb.pop_front(); tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL direct step%0d got %h want %h", i, obs, exp_v);
         end
      end
      tests_run++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || sel !== 1'b1 || hold_cnt !== '0) begin
         tests_failed++;
         $display("FAIL direct_handoff got %h want gnt1=1 sel=1 cnt=0", obs);
      end
   endtask

   task automatic test_forced();
      int switches = 0;
      logic prev_g0 = gnt0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 1'b1, 1'b1);
         exp_v = sb.pop_front(); tests_run++;
         if (obs !== exp_v || (gnt0 && gnt1)) begin
            tests_failed++;
            $display("FAIL forced cyc%0d got %h want %h", i, obs, exp_v);
         end
         if (gnt0 !== prev_g0) switches++;
         prev_g0 = gnt0;
      end
      tests_run++;
      if (switches < 4) begin
         tests_failed++;
         $display("FAIL forced_alternation got %0d switches want >=4", switches);
      end
   endtask

   task automatic test_drop_at_limit();
      drive(1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < MAX_HOLD; i++) begin
         drive(1'b1, 1'b1, 1'b1);
         exp_v = sb.pop_front(); tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL drop_limit cyc%0d got %h want %h", i, obs, exp_v);
         end
      end
      drive(1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); tests_run++;
      if (obs !== exp_v || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_limit_idle got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_hog();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         exp_v = sb.pop_front(); tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL hog cyc%0d got %h want %h", i, obs, exp_v);
         end
      end
      tests_run++;
      if (gnt0 !== 1'b1 || hold_cnt !== CNT_W'(MAX_HOLD - 1)) begin
         tests_failed++;
         $display("FAIL hog_saturate got gnt0=%b cnt=%0d want 1/%0d", gnt0, hold_cnt, MAX_HOLD - 1);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         exp_v = sb.pop_front(); tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_own1 cyc%0d got %h want %h", i, obs, exp_v);
         end
      end
      tests_run++;
      if (gnt1 !== 1'b1 || hold_cnt !== CNT_W'(3)) begin
         tests_failed++;
         $display("FAIL reset_mid_pre got gnt1=%b cnt=%0d want 1/3", gnt1, hold_cnt);
      end
      drive(1'b0, 1'b0, 1'b1);
      exp_v = sb.pop_front(); tests_run++;
      if (obs !== exp_v || gnt1 !== 1'b0 || sel !== 1'b0 || hold_cnt !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_drop got %h want %h", obs, exp_v);
      end
      drive(1'b1, 1'b1, 1'b1);
      exp_v = sb.pop_front(); tests_run++;
      if (obs !== exp_v || gnt0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_regrant got %h want %h (gnt0=1)", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_direct();
      test_forced();
      test_drop_at_limit();
      test_hog();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
